ex_result_stage: RTL

EX_RESULT_STAGE -- requirements
Module: ex_result_stage

---
 rtl/ex_result_stage_pkg.sv | 37 +++
 rtl/ex_result_stage_squash_ctr.sv | 43 ++++
 rtl/ex_result_stage.sv | 107 ++++++++++
 3 files changed

// File: rtl/ex_result_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ex_result_stage_pkg                                                  |
// | Shared encodings for the execute result stage: op classes, ALU       |
// | opcode constants and the default wrong-path squash depth.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ex_result_stage_pkg;

  // Result class delivered alongside each ALU result
  typedef enum logic [1:0] {
    OP_ARITH  = 2'b00,
    OP_CMP    = 2'b01,
    OP_BRANCH = 2'b10,
    OP_RSVD   = 2'b11
  } op_class_e;

  // Wrong-path instructions dropped after a taken branch
  localparam int SQUASH_DEFAULT = 2;

  // ALU opcode constants shared with the upstream ALU
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLT = 4'h5;
  localparam logic [3:0] ALU_SLL = 4'h6;
  localparam logic [3:0] ALU_SRL = 4'h7;

  // Counter width able to hold n; never below one bit so n = 0 still builds
  function automatic int ctr_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_result_stage_squash_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | squash_ctr                                                           |
// | Counts down wrong-path instructions after a taken branch. While      |
// | non-zero every accepted instruction is dropped and decrements it.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module squash_ctr
  import ex_result_stage_pkg::*;
#(
  parameter int SQUASH = SQUASH_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic accept,
  input  logic taken,
  output logic active
);

  localparam int CW = ctr_width(SQUASH);
  localparam logic [CW-1:0] LOAD_VAL = CW'(SQUASH);

  logic [CW-1:0] cnt;

  // Decrement on every accepted instruction while squashing; otherwise a
  // taken branch arms the counter (a taken branch inside the window is
  // itself squashed and does not reload)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (accept) begin
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end else if (taken) begin
        cnt <= LOAD_VAL;
      end
    end
  end

  assign active = (cnt != '0);

endmodule
`default_nettype wire

// File: rtl/ex_result_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ex_result_stage                                                      |
// | One-entry result register between the ALU and writeback. Formats     |
// | ARITH/CMP results, resolves taken branches into a redirect pulse,    |
// | drops wrong-path instructions and counts taken branches.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ex_result_stage
  import ex_result_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4,
  parameter int SQUASH = SQUASH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cmp,
  input  logic [1:0]        op_class,
  input  logic [RD_W-1:0]   rd,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [15:0]       br_off,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [15:0]       taken_cnt
);

  logic              accept;
  logic              is_taken;
  logic              squash_active;
  logic              keep;
  logic [DATA_W-1:0] br_disp;
  logic [DATA_W-1:0] br_target;

  // out_valid is cleared in reset, so the stage advertises ready then too
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_taken = (op_class_e'(op_class) == OP_BRANCH) && alu_cmp;
  assign keep     = accept && !squash_active;

  // Word offset: sign-extend and scale by 4; the add wraps modulo 2^DATA_W
  assign br_disp   = {{(DATA_W-18){br_off[15]}}, br_off, 2'b00};
  assign br_target = pc_plus4 + br_disp;

  squash_ctr #(
    .SQUASH (SQUASH)
  ) u_squash_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .accept  (accept),
    .taken   (is_taken),
    .active  (squash_active)
  );

  // Output entry, redirect pulse and taken-branch statistics
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      wb_en       <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      taken_cnt   <= '0;
    end else begin
      redirect <= keep && is_taken;

      if (keep) begin
        out_valid <= 1'b1;
        wb_rd     <= rd;
        case (op_class_e'(op_class))
          OP_ARITH: begin
            wb_en   <= 1'b1;
            wb_data <= alu_out;
          end
          OP_CMP: begin
            wb_en   <= 1'b1;
            wb_data <= {{(DATA_W-1){1'b0}}, alu_cmp};
          end
          default: begin
            wb_en   <= 1'b0;
            wb_data <= '0;
          end
        endcase
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (keep && is_taken) begin
        redirect_pc <= br_target;
        if (taken_cnt != 16'hFFFF) begin
          taken_cnt <= taken_cnt + 16'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire
